// File: rtl/e203_exu_csr_mcore.sv
// Machine-mode CSR file for the EXU: mstatus/mie/mtvec/mscratch/mepc/mcause/
// mtval/mip, 32/64-bit mcycle/minstret, mhartid, trap/mret stacking.
// Optional: `define E203_CSR_MCOUNTINHIBIT_EN adds mcountinhibit at 0x320.
`timescale 1ns/1ps
module e203_exu_csr_mcore #(
  parameter int XLEN      = 32,
  parameter int PC_SIZE   = 32,
  parameter int CNT_W     = 64,
  parameter int HART_ID_W = 1,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 csr_ena,
  input  logic                 csr_wr_en,
  input  logic                 csr_rd_en,
  input  logic [11:0]          csr_idx,
  input  logic [XLEN-1:0]      wbck_csr_dat,
  output logic [XLEN-1:0]      read_csr_dat,
  output logic                 csr_access_ilgl,
  input  logic [HART_ID_W-1:0] core_mhartid,
  input  logic                 ext_irq_r,
  input  logic                 tmr_irq_r,
  input  logic                 sft_irq_r,
  input  logic                 cmt_trap_ena,
  input  logic [PC_SIZE-1:0]   cmt_epc,
  input  logic [XLEN-1:0]      cmt_cause,
  input  logic [XLEN-1:0]      cmt_badaddr,
  input  logic                 cmt_mret_ena,
  input  logic                 cmt_instret_ena,
  input  logic                 dbg_mode,
  input  logic                 dbg_stopcycle,
  output logic                 status_mie_r,
  output logic                 meie_r,
  output logic                 mtie_r,
  output logic                 msie_r,
  output logic [PC_SIZE-1:0]   csr_epc_r,
  output logic [XLEN-1:0]      csr_mtvec_r
);
  logic               r_mie, r_mpie, r_meie, r_mtie, r_msie;
  logic [XLEN-1:0]    r_mtvec, r_mscratch, r_mcause, r_mtval;
  logic [PC_SIZE-1:0] r_mepc;
  logic [CNT_W-1:0]   r_mcycle, r_minstret;
  logic [63:0]        w_cyc64, w_ir64, w_cyc_nxt, w_ir_nxt;
  logic               w_cyc_wr, w_ir_wr, w_cyc_inc, w_ir_inc;
  logic               w_inh_cy, w_inh_ir;
  logic               w_mapped, w_ilgl, w_wen;
  logic [XLEN-1:0]    w_rdat;
  logic [31:0]        w_wd;
  logic [PC_SIZE-1:0] w_wpc;
  logic               w_unused;

  assign w_unused = csr_rd_en;   // reads are qualified by csr_ena alone
  assign w_cyc64  = 64'(r_mcycle);
  assign w_ir64   = 64'(r_minstret);
  assign w_wd     = wbck_csr_dat[31:0];
  assign w_wpc    = PC_SIZE'(wbck_csr_dat);

`ifdef E203_CSR_MCOUNTINHIBIT_EN
  logic r_inh_cy, r_inh_ir;
  assign w_inh_cy = r_inh_cy;
  assign w_inh_ir = r_inh_ir;
`else
  assign w_inh_cy = 1'b0;
  assign w_inh_ir = 1'b0;
`endif

  // Address decode and read mux
  always_comb begin
    w_mapped = 1'b1;
    w_rdat   = '0;
    case (csr_idx)
      12'h300: w_rdat = XLEN'({2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0});
      12'h304: w_rdat = XLEN'({r_meie, 3'b0, r_mtie, 3'b0, r_msie, 3'b0});
      12'h305: w_rdat = r_mtvec;
      12'h340: w_rdat = r_mscratch;
      12'h341: w_rdat = XLEN'(r_mepc);
      12'h342: w_rdat = r_mcause;
      12'h343: w_rdat = r_mtval;
      12'h344: w_rdat = XLEN'({ext_irq_r, 3'b0, tmr_irq_r, 3'b0, sft_irq_r, 3'b0});
      12'hB00: w_rdat = XLEN'(w_cyc64[31:0]);
      12'hB80: w_rdat = XLEN'(w_cyc64[63:32]);
      12'hB02: w_rdat = XLEN'(w_ir64[31:0]);
      12'hB82: w_rdat = XLEN'(w_ir64[63:32]);
      12'hF14: w_rdat = XLEN'(core_mhartid);
`ifdef E203_CSR_MCOUNTINHIBIT_EN
      12'h320: w_rdat = XLEN'({r_inh_ir, 1'b0, r_inh_cy});
`endif
      default: w_mapped = 1'b0;
    endcase
  end

  // Read-only space (idx[11:10]==11) rejects writes; trap/mret drop CSR writes
  assign w_ilgl          = csr_ena & (~w_mapped | (csr_wr_en & (csr_idx[11:10] == 2'b11)));
  assign csr_access_ilgl = w_ilgl;
  assign read_csr_dat    = (csr_ena & ~w_ilgl) ? w_rdat : '0;
  assign w_wen           = csr_ena & csr_wr_en & ~w_ilgl & ~cmt_trap_ena & ~cmt_mret_ena;

  assign w_cyc_inc = ~(dbg_mode & dbg_stopcycle) & ~w_inh_cy;
  assign w_ir_inc  = cmt_instret_ena & ~dbg_mode & ~w_inh_ir;

  // Counter next values: a written half holds exactly, else increment.
  // Computed at 64 bits and truncated, so CNT_W=32 wraps naturally.
  always_comb begin
    w_cyc_nxt = w_cyc64;
    w_ir_nxt  = w_ir64;
    w_cyc_wr  = 1'b0;
    w_ir_wr   = 1'b0;
    if (w_wen && csr_idx == 12'hB00) begin w_cyc_nxt[31:0] = w_wd; w_cyc_wr = 1'b1; end
    if (w_wen && csr_idx == 12'hB80 && CNT_W == 64) begin w_cyc_nxt[63:32] = w_wd; w_cyc_wr = 1'b1; end
    if (w_wen && csr_idx == 12'hB02) begin w_ir_nxt[31:0] = w_wd; w_ir_wr = 1'b1; end
    if (w_wen && csr_idx == 12'hB82 && CNT_W == 64) begin w_ir_nxt[63:32] = w_wd; w_ir_wr = 1'b1; end
    if (!w_cyc_wr && w_cyc_inc) w_cyc_nxt = w_cyc64 + 64'd1;
    if (!w_ir_wr && w_ir_inc)   w_ir_nxt  = w_ir64 + 64'd1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      r_mcycle   <= w_cyc_nxt[CNT_W-1:0];
      r_minstret <= w_ir_nxt[CNT_W-1:0];
    end
  end

  // mstatus interrupt-enable stack: trap > mret > CSR write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
    end else if (cmt_trap_ena) begin
      r_mpie <= r_mie;
      r_mie  <= 1'b0;
    end else if (cmt_mret_ena) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_wen && csr_idx == 12'h300) begin
      r_mie  <= w_wd[3];
      r_mpie <= w_wd[7];
    end
  end

  // Trap capture and plain read/write CSRs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meie <= 1'b0; r_mtie <= 1'b0; r_msie <= 1'b0;
      r_mtvec    <= MTVEC_RST;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else if (cmt_trap_ena) begin
      r_mepc   <= {cmt_epc[PC_SIZE-1:1], 1'b0};
      r_mcause <= cmt_cause;
      r_mtval  <= cmt_badaddr;
    end else if (w_wen) begin
      case (csr_idx)
        12'h304: begin r_meie <= w_wd[11]; r_mtie <= w_wd[7]; r_msie <= w_wd[3]; end
        12'h305: r_mtvec    <= wbck_csr_dat;
        12'h340: r_mscratch <= wbck_csr_dat;
        12'h341: r_mepc     <= {w_wpc[PC_SIZE-1:1], 1'b0};
        12'h342: r_mcause   <= wbck_csr_dat;
        12'h343: r_mtval    <= wbck_csr_dat;
        default: ;
      endcase
    end
  end

`ifdef E203_CSR_MCOUNTINHIBIT_EN
  // mcountinhibit CY/IR bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inh_cy <= 1'b0;
      r_inh_ir <= 1'b0;
    end else if (w_wen && csr_idx == 12'h320) begin
      r_inh_cy <= w_wd[0];
      r_inh_ir <= w_wd[2];
    end
  end
`endif

  assign status_mie_r = r_mie;
  assign meie_r       = r_meie;
  assign mtie_r       = r_mtie;
  assign msie_r       = r_msie;
  assign csr_epc_r    = r_mepc;
  assign csr_mtvec_r  = r_mtvec;
endmodule
